// File: rtl/inv_shiftrows_stage.sv
// Registered, handshaked (Inv)ShiftRows stage with a 2-entry output FIFO.
// Optional delivery self-check: define INV_SHIFTROWS_SELFCHECK_EN.
module inv_shiftrows_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             decrypt,
    input  logic [31:0]      line0,
    input  logic [31:0]      line1,
    input  logic [31:0]      line2,
    input  logic [31:0]      line3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      outline0,
    output logic [31:0]      outline1,
    output logic [31:0]      outline2,
    output logic [31:0]      outline3,
    output logic [CNT_W-1:0] blk_count,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Element r of a state_t is state row r.
    typedef logic [3:0][31:0] state_t;

    // inv=1 rotates row r right by r bytes, inv=0 rotates it left by r bytes.
    function automatic state_t shift_rows(input state_t s, input logic inv);
        state_t      r;
        logic [63:0] dd;
        for (int i = 0; i < 4; i++) begin
            dd   = {s[i], s[i]};
            r[i] = inv ? dd[8*i +: 32] : dd[(32 - 8*i) +: 32];
        end
        return r;
    endfunction

    state_t             in_st;
    state_t             xf;
    state_t             mem_q [DEPTH];
    state_t             out_q;
    state_t             head_data;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [1:0]         count_q, count_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   blk_q;
    logic               accept;
    logic               deliver;

    assign in_st   = {line3, line2, line1, line0};
    assign xf      = shift_rows(in_st, decrypt);
    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid_q & out_ready;

    always_comb begin
        count_d = count_q;
        case ({accept, deliver})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d = head_q + PTR_W'(deliver);
        tail_d = tail_q + PTR_W'(accept);
        // The slot being written this cycle may be the next head (empty, or
        // simultaneous accept+deliver at count 1), so bypass the array then.
        if (accept && (tail_q == head_d))
            head_data = xf;
        else
            head_data = mem_q[head_d];
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem_q[tail_q] <= xf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            blk_q       <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= (32'(count_d) < DEPTH);
            out_valid_q <= (count_d != 2'd0);
            if (count_d != 2'd0)
                out_q <= head_data;
            if (deliver)
                blk_q <= blk_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef INV_SHIFTROWS_SELFCHECK_EN
    state_t raw_q [DEPTH];
    logic   dec_q [DEPTH];
    state_t undo;
    logic   err_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            raw_q[tail_q] <= in_st;
            dec_q[tail_q] <= decrypt;
        end
    end

    // The head slot always still holds the raw rows of the state on the outputs.
    assign undo = shift_rows(out_q, ~dec_q[head_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (deliver && (undo != raw_q[head_q]))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign outline0  = out_q[0];
    assign outline1  = out_q[1];
    assign outline2  = out_q[2];
    assign outline3  = out_q[3];
    assign blk_count = blk_q;

endmodule

// File: tb/tb_inv_shiftrows_stage.sv
// Directed bench for inv_shiftrows_stage: spec vectors, backpressure,
// streaming with mixed modes, reset mid-operation and counter wrap (CNT_W=4).
module tb_inv_shiftrows_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        decrypt;
    logic [31:0] line0, line1, line2, line3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] outline0, outline1, outline2, outline3;
    logic [3:0]  blk_count;
    logic        err;

    always #5 clk = ~clk;

    inv_shiftrows_stage #(.DEPTH(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decrypt   (decrypt),
        .line0     (line0),
        .line1     (line1),
        .line2     (line2),
        .line3     (line3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outline0  (outline0),
        .outline1  (outline1),
        .outline2  (outline2),
        .outline3  (outline3),
        .blk_count (blk_count),
        .err       (err)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [127:0]  exp_q[$];
    logic [127:0]  last_m   = '0;
    logic [3:0]    cnt_m    = 4'd0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs written directly from the row equations, {row0,row1,row2,row3}.
    function automatic logic [127:0] model(input logic dec, input logic [31:0] a, b, c, d);
        if (dec)
            return {a, {b[7:0], b[31:8]}, {c[15:0], c[31:16]}, {d[23:0], d[31:24]}};
        else
            return {a, {b[23:0], b[31:24]}, {c[15:0], c[31:16]}, {d[7:0], d[31:8]}};
    endfunction

    function automatic logic [127:0] outs();
        return {outline0, outline1, outline2, outline3};
    endfunction

    // One clock cycle: drive at the falling edge, check, update the model.
    task automatic step(input logic iv, input logic dec, input logic [31:0] a, b, c, d,
                        input logic ordy);
        int  pre_size;
        logic acc, dlv;
        @(negedge clk);
        in_valid = iv; decrypt = dec; out_ready = ordy;
        line0 = a; line1 = b; line2 = c; line3 = d;
        #1;
        pre_size = exp_q.size();
        acc = iv && (pre_size < 2);
        dlv = ordy && (pre_size != 0);
        check("in_ready", 128'(in_ready), 128'(pre_size < 2));
        check("out_valid", 128'(out_valid), 128'(pre_size != 0));
        check("blk_count", 128'(blk_count), 128'(cnt_m));
        check("err", 128'(err), 128'(0));
        if (pre_size != 0) check("outline", outs(), exp_q[0]);
        else               check("outline_hold", outs(), last_m);
        if (dlv) begin
            last_m = exp_q.pop_front();
            cnt_m  = cnt_m + 4'd1;
            $display("deliver n=%0d rows=%h", cnt_m, last_m);
        end
        if (acc) begin
            exp_q.push_back(model(dec, a, b, c, d));
            $display("accept dec=%0b rows=%h_%h_%h_%h", dec, a, b, c, d);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_blk_count", 128'(blk_count), 128'(0));
        check("rst_outline", outs(), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        exp_q.delete();
        cnt_m  = 4'd0;
        last_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b0;
        line0 = '0; line1 = '0; line2 = '0; line3 = '0;
        do_reset();

        // Decrypt vector: output one cycle after accept.
        step(1'b1, 1'b1, 32'h00112233, 32'h01020304, 32'h05060708, 32'h090A0B0C, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        check("dec_vector", outs(), 128'h00112233_04010203_07080506_0A0B0C09);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        check("dec_blk_count", 128'(blk_count), 128'(1));

        // Encrypt vector.
        step(1'b1, 1'b0, 32'h00112233, 32'h01020304, 32'h05060708, 32'h090A0B0C, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        check("enc_vector", outs(), 128'h00112233_02030401_07080506_0C090A0B);
        idle(1);

        // Backpressure: two accepted, third refused until the first delivers.
        step(1'b1, 1'b1, 32'hA0A1A2A3, 32'hA4A5A6A7, 32'hA8A9AAAB, 32'hACADAEAF, 1'b0);
        step(1'b1, 1'b0, 32'hB0B1B2B3, 32'hB4B5B6B7, 32'hB8B9BABB, 32'hBCBDBEBF, 1'b0);
        step(1'b1, 1'b1, 32'hC0C1C2C3, 32'hC4C5C6C7, 32'hC8C9CACB, 32'hCCCDCECF, 1'b0);
        check("full_in_ready", 128'(in_ready), 128'(0));
        step(1'b1, 1'b1, 32'hC0C1C2C3, 32'hC4C5C6C7, 32'hC8C9CACB, 32'hCCCDCECF, 1'b0);
        check("stall_hold", outs(), 128'hA0A1A2A3_A7A4A5A6_AAABA8A9_ADAEAFAC);
        step(1'b1, 1'b1, 32'hC0C1C2C3, 32'hC4C5C6C7, 32'hC8C9CACB, 32'hCCCDCECF, 1'b1);
        step(1'b1, 1'b1, 32'hC0C1C2C3, 32'hC4C5C6C7, 32'hC8C9CACB, 32'hCCCDCECF, 1'b1);
        idle(3);

        // Streaming at count=1 with alternating modes: one deliver per cycle.
        step(1'b1, 1'b0, 32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b1, i[0], 32'h50000000 + i, 32'h60010203 + i, 32'h70040506 + i,
                 32'h80070809 + i, 1'b1);
        check("stream_full_rate", 128'(exp_q.size()), 128'(1));
        idle(3);

        // Reset with two states buffered; nothing stale may follow.
        step(1'b1, 1'b1, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h76543210, 1'b0);
        step(1'b1, 1'b0, 32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        do_reset();
        idle(3);

        // Counter wrap: 17 deliveries with a 4-bit counter.
        for (int i = 0; i < 17; i++)
            step(1'b1, i[1], 32'h00000100 * i, 32'h0A0B0C0D ^ i, 32'h1F2E3D4C + i,
                 32'h99887766 - i, 1'b1);
        idle(2);
        check("wrap_blk_count", 128'(blk_count), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_shiftrows_stage.md
Name: inv_shiftrows_stage

Overview:
- Registered, handshaked ShiftRows stage for the AES datapath. Applies InvShiftRows on decrypt and forward ShiftRows on encrypt, so the decrypt pipeline has its own stage.
- Holds up to two states in a 2-entry output buffer with valid/ready on both sides. Upstream and downstream (SubBytes / AddRoundKey stages) can stall independently.
- State is carried as four 32-bit row lines. Byte [31:24] of each line is column 0; byte [7:0] is column 3.

Parameters:
- DEPTH, 2, output buffer entries; fixed at 2, other values unsupported.
- CNT_W, 16, width of the processed-block counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers a state this cycle.
- in_ready  output  1  stage can accept a state this cycle.
- decrypt  input  1  1 = InvShiftRows, 0 = forward ShiftRows; sampled with the state.
- line0..line3  input  32 each  input state rows 0..3.
- out_valid  output  1  outline0..3 hold a valid state.
- out_ready  input  1  downstream accepts the state this cycle.
- outline0..outline3  output  32 each  transformed state rows.
- blk_count  output  CNT_W  number of states delivered (out_valid & out_ready).
- err  output  1  sticky self-check error (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - buffer empty; in_ready=1; out_valid=0.
  - outline0..3=0; blk_count=0; err=0.
- Transform (combinational on input, written into the buffer on accept):
  - Decrypt, each row rotated right by r bytes:
    - row0 unchanged
    - row1 = {line1[7:0], line1[31:8]}
    - row2 = {line2[15:0], line2[31:16]}
    - row3 = {line3[23:0], line3[31:24]}
  - Encrypt, each row rotated left by r bytes:
    - row1 = {line1[23:0], line1[31:24]}
    - row2 = {line2[15:0], line2[31:16]}
    - row3 = {line3[7:0], line3[31:8]}
- Handshake:
  - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
  - in_ready = (count < 2); registered, with no combinational path from out_ready.
  - Latency: a state accepted in cycle N into an empty buffer gives out_valid=1 in cycle N+1.
  - Outputs come from the head entry. They hold stable while out_valid=1 and out_ready=0.
- Buffer is a 2-entry FIFO with head/tail pointers that wrap modulo 2 and a 2-bit count (0..2):
  - accept only: count+1.
  - deliver only: count-1; head advances.
  - accept and deliver in the same cycle with count=1: count stays 1. The new entry becomes head next cycle, so there is no bubble.
  - count=2: in_ready=0 and accept is impossible. A deliver frees one slot, and in_ready=1 the next cycle.
  - count=0: out_valid=0, and outline0..3 hold their last value (0 after reset).
- blk_count increments on each deliver and wraps from 2^CNT_W-1 to 0.
- decrypt is stored per entry, so entries with mixed modes may be in flight together.
- Reset mid-operation: buffered states are discarded with no partial deliver; all outputs return to reset values immediately.

Optional Feature:
- Macro: INV_SHIFTROWS_SELFCHECK_EN.
- Defined:
  - Each entry also stores the raw input rows.
  - On deliver, the opposite transform is applied to outline0..3 and compared with the stored input.
  - A mismatch sets err=1. err stays set until rst_n.
- Undefined: raw rows are not stored and err is tied to 0.

Test Plan:
- Decrypt, single state: line0..3 = 00112233/01020304/05060708/090A0B0C, out_ready=1, accept in cycle N -> out_valid in N+1 with outline0..3 = 00112233/04010203/07080506/0A0B0C09; blk_count=1.
- Encrypt, same rows, decrypt=0 -> outline1=02030401, outline2=07080506, outline3=0C090A0B; outline0 unchanged.
- Backpressure: out_ready=0, offer 3 states -> two accepted, in_ready=0 on the third; outputs stable. Raise out_ready -> delivered in order, third accepted the cycle after the first deliver.
- Streaming at count=1: in_valid=out_ready=1 for 10 cycles with alternating decrypt -> one deliver per cycle, no bubble, correct mode per state, blk_count=10.
- Counter wrap: force CNT_W=4, deliver 17 states -> blk_count=1.
- Reset mid-operation: rst_n low with count=2 -> out_valid=0, in_ready=1, blk_count=0 immediately; no stale state appears after release. With INV_SHIFTROWS_SELFCHECK_EN, normal traffic keeps err=0.
